issue_hazard_unit: RTL
======================

Name: issue_hazard_unit

Overview:
- Sits between the decode controller and the execute stage of the CPU pipeline.
- Consumes per-instruction decode flags: rs*_used, bs_used, RegWrite, BitmapWrite, ALUBR, HALT.
- Tracks in-flight register and bitmap writes in a shift-register scoreboard, and stalls decode on read-after-write hazards (no forwarding path exists).
- Inserts bubbles into EX, kills the decode slot on a taken branch, and latches a halted state on HALT.

Parameters:
- REG_AW, 4, register-file address width
- BM_AW, 2, bitmap-register-file address width
- WB_LAT, 3, cycles from issue until the write lands in the register files (EX, MEM, WB); legal range 1..6
- WB_BYPASS, 1, 1 = register files write before read, so the final scoreboard entry is not a hazard

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- rs1_used, rs2_used, bs_used  in  1 each  source-usage flags from the controller
- rs1_addr, rs2_addr  in  REG_AW each  source register indices
- bs_addr  in  BM_AW  source bitmap index
- reg_write, bitmap_write  in  1 each  destination-write flags from the controller
- rd_addr  in  REG_AW  destination register index
- bd_addr  in  BM_AW  destination bitmap index
- is_halt  in  1  HALT decoded
- br_taken  in  1  EX reports a taken branch/return this cycle
- stall  out  1  hold PC and IF/ID register
- issue  out  1  decode instruction advances to EX this cycle
- flush  out  1  squash the IF/ID register
- ex_valid  out  1  registered; EX stage holds a real instruction
- halted  out  1  registered; CPU halted
- hazard_count  out  16  registered saturating count of stall cycles

Behaviour:
- Reset (asynchronous, immediate): all scoreboard entries invalid; ex_valid=0; halted=0; hazard_count=0. Combinational outputs follow from the cleared state: stall = id_valid & hazard, issue=0 unless id_valid, flush=br_taken. Reset mid-stall discards all in-flight tracking.
- Scoreboard: WB_LAT entries, each {v, is_bm, addr[max(REG_AW,BM_AW)-1:0]}. Entry 0 is youngest.
  - Every clk edge shifts entries 0→1→…→WB_LAT-1; the last entry retires.
  - Entry 0 loads {reg_write|bitmap_write, bitmap_write, dest} when issue=1. Otherwise it loads v=0 (bubble).
  - An instruction asserting both write flags records the bitmap destination only; the register write is ignored and flagged by assertion.
- Hazard check (combinational), true if any counted entry is valid and matches:
  - (rs1_used & !is_bm & addr==rs1_addr) | (rs2_used & !is_bm & addr==rs2_addr) | (bs_used & is_bm & addr==bs_addr)
  - Counted entries: 0..WB_LAT-2 when WB_BYPASS=1; all entries otherwise.
- Outputs, in priority order:
  - flush = br_taken.
  - issue = id_valid & !hazard & !br_taken & !halted.
  - stall = id_valid & hazard & !br_taken, or halted.
  - ex_valid <= issue at each edge.
- Taken branch: when br_taken coincides with a hazard, flush wins; the decode instruction is discarded and no entry is pushed. Older scoreboard entries stay valid.
- HALT: when issue & is_halt, halted <= 1 next edge. Once halted, stall=1 and issue=0 permanently; the scoreboard keeps shifting and drains. Only rst clears halted. A HALT stalled by a hazard does not halt until it issues. A HALT killed by br_taken does not halt.
- hazard_count increments each cycle that id_valid & hazard & !br_taken; it saturates at 16'hFFFF.
- Latency: issue is same-cycle combinational; a pushed destination blocks readers starting the following cycle. A dependent instruction directly behind a writer therefore stalls WB_LAT-1 cycles (WB_BYPASS=1) or WB_LAT cycles (WB_BYPASS=0).
- Reads of a destination the same instruction writes (e.g. ADD r1,r1,r2) are not self-hazards.

Decomposition:
- Shared package cpu_pkg: REG_AW, BM_AW, WB_LAT defaults, and the scoreboard entry typedef sb_entry_t {v, is_bm, addr}.
- One sub-module, hazard_scoreboard: the shift register plus the match logic, returning hazard. The top holds the issue/flush/halt control and the counter.

Test Plan:
- ADD r3 issued, then SUB reading rs1=r3 (WB_LAT=3, WB_BYPASS=1) → stall=1 for exactly 2 cycles; issue on the 3rd cycle; hazard_count=2.
- BSL writing b1, then PLY with bs_addr=1, then PLY with bs_addr=2 → first PLY stalls 2 cycles; second PLY issues without stalling; register index 1 is not confused with bitmap 1.
- Writer r5, dependent reader stalled, br_taken=1 during the stall → flush=1, issue=0, no entry pushed. Next cycle, an independent instruction issues immediately.
- HALT with id_valid=1, no hazard → halted=1 after one edge. Thereafter stall=1 and issue=0 for 20 cycles; the scoreboard drains to all-invalid.
- rst pulsed asynchronously mid-stall (between edges) → ex_valid=0, halted=0, hazard_count=0 immediately. The previously blocked reader issues in the first cycle after release.
- WB_BYPASS=0, WB_LAT=3, back-to-back dependent ADDs → each stalls 3 cycles; continuous id_valid yields a steady-state issue rate of 1 per 4 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the decode/issue boundary of the CPU pipeline.
//   REG_AW_DEFAULT : register-file address width
//   BM_AW_DEFAULT  : bitmap-register-file address width
//   WB_LAT_DEFAULT : cycles from issue until a write lands (EX, MEM, WB)
//   SB_AW          : scoreboard address width, wide enough for either file
//   sb_entry_t     : one in-flight destination {v, is_bm, addr}
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_AW_DEFAULT = 4;
    localparam int BM_AW_DEFAULT  = 2;
    localparam int WB_LAT_DEFAULT = 3;

    localparam int SB_AW = (REG_AW_DEFAULT > BM_AW_DEFAULT) ? REG_AW_DEFAULT : BM_AW_DEFAULT;

    typedef struct packed {
        logic             v;
        logic             is_bm;
        logic [SB_AW-1:0] addr;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Shift-register record of destinations still in flight between issue and
// write-back, plus the read-after-write match against the decode sources.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   i_push              : the decode instruction issues with a destination
//   i_push_bm           : that destination is a bitmap register
//   i_push_addr         : destination index (zero-extended)
//   i_rs1_used/_addr    : register source 1
//   i_rs2_used/_addr    : register source 2
//   i_bs_used/_addr     : bitmap source
//   o_hazard            : a source matches a counted in-flight destination
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int WB_LAT    = WB_LAT_DEFAULT,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_push_bm,
    input  logic [SB_AW-1:0] i_push_addr,
    input  logic             i_rs1_used,
    input  logic [SB_AW-1:0] i_rs1_addr,
    input  logic             i_rs2_used,
    input  logic [SB_AW-1:0] i_rs2_addr,
    input  logic             i_bs_used,
    input  logic [SB_AW-1:0] i_bs_addr,
    output logic             o_hazard
);

    // With write-before-read register files the oldest entry lands in the
    // same cycle a reader would fetch it, so it no longer blocks.
    localparam int N_CHK = WB_BYPASS ? WB_LAT - 1 : WB_LAT;

    sb_entry_t r_sb [WB_LAT];
    sb_entry_t w_push;

    // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_push = '0;
        if (i_push) begin
            w_push.v     = 1'b1;
            w_push.is_bm = i_push_bm;
            w_push.addr  = i_push_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every entry shifts from its pre-edge value.
    // NOTE: the entry array is a handful of flops, not RAM, and its valid bits must clear on reset, so every entry is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WB_LAT; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_sb[0] <= w_push;
            for (int i = 1; i < WB_LAT; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    always_comb begin
        o_hazard = 1'b0;
        for (int i = 0; i < N_CHK; i++) begin
            if (r_sb[i].v) begin
                if (r_sb[i].is_bm) begin
                    if (i_bs_used && (r_sb[i].addr == i_bs_addr)) begin
                        o_hazard = 1'b1;
                    end
                end else begin
                    if ((i_rs1_used && (r_sb[i].addr == i_rs1_addr)) ||
                        (i_rs2_used && (r_sb[i].addr == i_rs2_addr))) begin
                        o_hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/issue_hazard_unit.sv
// ---------------------------------------------------------------------------
// issue_hazard_unit
// Issue control between decode and execute. Stalls decode on read-after-
// write hazards (no forwarding), inserts bubbles into EX, squashes the
// decode slot on a taken branch and latches a halted state on HALT.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   id_valid                    : decode slot holds a real instruction
//   rs1/rs2/bs_used, _addr      : source usage flags and indices
//   reg_write, rd_addr          : register destination
//   bitmap_write, bd_addr       : bitmap destination
//   is_halt                     : HALT decoded
//   br_taken                    : EX reports a taken branch/return
//   stall                       : hold PC and IF/ID
//   issue                       : decode instruction advances to EX
//   flush                       : squash IF/ID
//   ex_valid                    : registered, EX holds a real instruction
//   halted                      : registered, CPU halted
//   hazard_count                : registered saturating count of stall cycles
// ---------------------------------------------------------------------------
module issue_hazard_unit
    import cpu_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEFAULT,
    parameter int BM_AW     = BM_AW_DEFAULT,
    parameter int WB_LAT    = WB_LAT_DEFAULT,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              bs_used,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [BM_AW-1:0]  bs_addr,
    input  logic              reg_write,
    input  logic              bitmap_write,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [BM_AW-1:0]  bd_addr,
    input  logic              is_halt,
    input  logic              br_taken,
    output logic              stall,
    output logic              issue,
    output logic              flush,
    output logic              ex_valid,
    output logic              halted,
    output logic [15:0]       hazard_count
);

    if (WB_LAT < 1 || WB_LAT > 6) begin : g_bad_wb_lat
        $error("issue_hazard_unit: WB_LAT must be 1..6");
    end
    if (REG_AW > SB_AW || BM_AW > SB_AW) begin : g_bad_aw
        $error("issue_hazard_unit: address width exceeds scoreboard width");
    end

    logic             w_hazard;
    logic             w_issue;
    logic             w_count_en;
    logic             w_push;
    logic [SB_AW-1:0] w_push_addr;

    logic             r_ex_valid;
    logic             r_halted;
    logic [15:0]      r_hazard_count;

    // Priority: a taken branch overrides everything, then halt, then hazard.
    assign w_issue    = id_valid & ~w_hazard & ~br_taken & ~r_halted;
    assign w_count_en = id_valid &  w_hazard & ~br_taken;

    assign flush = br_taken;
    assign issue = w_issue;
    assign stall = w_count_en | r_halted;

    // A dual-write instruction records only its bitmap destination.
    assign w_push      = w_issue & (reg_write | bitmap_write);
    assign w_push_addr = bitmap_write ? SB_AW'(bd_addr) : SB_AW'(rd_addr);

    hazard_scoreboard #(
        .WB_LAT    (WB_LAT),
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_bm   (bitmap_write),
        .i_push_addr (w_push_addr),
        .i_rs1_used  (rs1_used),
        .i_rs1_addr  (SB_AW'(rs1_addr)),
        .i_rs2_used  (rs2_used),
        .i_rs2_addr  (SB_AW'(rs2_addr)),
        .i_bs_used   (bs_used),
        .i_bs_addr   (SB_AW'(bs_addr)),
        .o_hazard    (w_hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_halted       <= 1'b0;
            r_hazard_count <= '0;
        end else begin
            r_ex_valid <= w_issue;
            if (w_issue && is_halt) begin
                r_halted <= 1'b1;
            end
            if (w_count_en && (r_hazard_count != 16'hFFFF)) begin
                r_hazard_count <= r_hazard_count + 16'd1;
            end
        end
    end

    assign ex_valid     = r_ex_valid;
    assign halted       = r_halted;
    assign hazard_count = r_hazard_count;

    a_single_dest: assert property (@(posedge clk) disable iff (rst)
        !(w_issue && reg_write && bitmap_write));

endmodule
